// File: rtl/cal_seq.sv
// cal_seq: calibration sweep sequencer (clk_sys domain).
// Steps the 6-bit calibration divider setting from a start value to a stop
// value. For each point it strobes cal_load, waits a settle interval, then
// holds cal_start for a dwell interval. Every output is a flop because
// cal_start and cal_para are consumed in the clk_dds domain.
module cal_seq #(
  parameter int DWELL_W  = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                seq_start,
  input  logic                seq_abort,
  input  logic [5:0]          para_first,
  input  logic [5:0]          para_last,
  input  logic [5:0]          para_step,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [5:0]          cal_para,
  output logic                cal_load,
  output logic                cal_start,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [5:0]          point_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0]  DWELL_ZERO  = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0]  DWELL_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};

  // FSM state
  logic [2:0]          state_q,  state_d;
  // Shadow copies of the sweep configuration, frozen for the whole sweep
  logic [5:0]          last_q,   last_d;
  logic [5:0]          step_q,   step_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DWELL_W-1:0]  dwell_q,  dwell_d;
  // Down-counters for the settle and dwell intervals
  logic [SETTLE_W-1:0] scnt_q,   scnt_d;
  logic [DWELL_W-1:0]  dcnt_q,   dcnt_d;
  // Current setting (doubles as the cal_para output flop) and point index
  logic [5:0]          cur_q,    cur_d;
  logic [5:0]          idx_q,    idx_d;
  // Output flops
  logic                load_q,   load_d;
  logic                start_q,  start_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic                abrt_q,   abrt_d;

  logic [6:0]          nxt_s;
  logic [DWELL_W-1:0]  dload_s;
  logic                abort_s;

  // Next-state, counter and output decode for the sweep sequencer
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    step_d   = step_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    scnt_d   = scnt_q;
    dcnt_d   = dcnt_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    abort_s  = 1'b0;

    // 7-bit sum so a step past 63 is visible in bit 6
    nxt_s = {1'b0, cur_q} + {1'b0, step_q};

    // RUN lasts dwell cycles, with dwell=0 behaving like dwell=1
    if (dwell_q == DWELL_ZERO) begin
      dload_s = DWELL_ZERO;
    end else begin
      dload_s = dwell_q - DWELL_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          last_d   = para_last;
          step_d   = para_step;
          settle_d = settle;
          dwell_d  = dwell;
          cur_d    = para_first;
          idx_d    = 6'd0;
          state_d  = S_LOAD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        if (settle_q != SETTLE_ZERO) begin
          scnt_d  = settle_q - SETTLE_ONE;
          state_d = S_SETTLE;
        end else begin
          dcnt_d  = dload_s;
          state_d = S_RUN;
        end
      end
      S_SETTLE: begin
        if (scnt_q == SETTLE_ZERO) begin
          dcnt_d  = dload_s;
          state_d = S_RUN;
        end else begin
          scnt_d  = scnt_q - SETTLE_ONE;
        end
      end
      S_RUN: begin
        if (dcnt_q == DWELL_ZERO) begin
          state_d = S_NEXT;
        end else begin
          dcnt_d  = dcnt_q - DWELL_ONE;
        end
      end
      S_NEXT: begin
        if ((step_q == 6'd0) || nxt_s[6] || (nxt_s[5:0] > last_q)) begin
          state_d = S_FIN;
        end else begin
          cur_d   = nxt_s[5:0];
          idx_d   = idx_q + 6'd1;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any transition outside IDLE; cal_para and the index
    // stay frozen because cal_para may only move together with cal_load
    if ((state_q != S_IDLE) && seq_abort) begin
      state_d = S_IDLE;
      cur_d   = cur_q;
      idx_d   = idx_q;
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end

    // Outputs are decoded from the next state and registered
    load_d  = (state_d == S_LOAD);
    start_d = (state_d == S_RUN);
    done_d  = (state_d == S_FIN);
    abrt_d  = abort_s;
    // busy stays high through the aborted-pulse cycle
    busy_d  = (state_d != S_IDLE) || abort_s;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 6'd0;
      step_q   <= 6'd0;
      settle_q <= SETTLE_ZERO;
      dwell_q  <= DWELL_ZERO;
      scnt_q   <= SETTLE_ZERO;
      dcnt_q   <= DWELL_ZERO;
      cur_q    <= 6'd0;
      idx_q    <= 6'd0;
      load_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      scnt_q   <= scnt_d;
      dcnt_q   <= dcnt_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      load_q   <= load_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
    end
  end

  assign cal_para  = cur_q;
  assign cal_load  = load_q;
  assign cal_start = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = abrt_q;
  assign point_idx = idx_q;

endmodule

// File: tb/tb_cal_seq.sv
// Self-checking bench for cal_seq. A timeline model expands each sweep into
// the expected per-cycle outputs from the point list and interval lengths.
module tb_cal_seq;

  logic        clk_sys;
  logic        rst_n;
  logic        seq_start;
  logic        seq_abort;
  logic [5:0]  para_first;
  logic [5:0]  para_last;
  logic [5:0]  para_step;
  logic [7:0]  settle;
  logic [15:0] dwell;
  logic [5:0]  cal_para;
  logic        cal_load;
  logic        cal_start;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [5:0]  point_idx;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [5:0] para;
    logic       load;
    logic       start;
    logic       busy;
    logic       done;
    logic       abrt;
    logic       chk_idx;
    logic [5:0] idx;
  } exp_t;

  exp_t exp_q[$];

  cal_seq #(.DWELL_W(16), .SETTLE_W(8)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .seq_start (seq_start),
    .seq_abort (seq_abort),
    .para_first(para_first),
    .para_last (para_last),
    .para_step (para_step),
    .settle    (settle),
    .dwell     (dwell),
    .cal_para  (cal_para),
    .cal_load  (cal_load),
    .cal_start (cal_start),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .point_idx (point_idx)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic exp_t mk(input int para, input bit ld, input bit st, input bit bz,
                              input bit dn, input bit ab, input bit ci, input int idx);
    exp_t e;
    e.para    = 6'(para);
    e.load    = ld;
    e.start   = st;
    e.busy    = bz;
    e.done    = dn;
    e.abrt    = ab;
    e.chk_idx = ci;
    e.idx     = 6'(idx);
    return e;
  endfunction

  // Expand one sweep into its expected cycle-by-cycle outputs
  task automatic build_model(input int first, input int last, input int step,
                             input int stl, input int dw);
    int pts[$];
    int p;
    int dwn;
    exp_q.delete();
    p = first;
    pts.push_back(p);
    while (step != 0 && p + step <= 63 && p + step <= last) begin
      p = p + step;
      pts.push_back(p);
    end
    dwn = (dw == 0) ? 1 : dw;
    for (int k = 0; k < pts.size(); k++) begin
      exp_q.push_back(mk(pts[k], 1, 0, 1, 0, 0, 1, k));
      for (int s = 0; s < stl; s++) exp_q.push_back(mk(pts[k], 0, 0, 1, 0, 0, 1, k));
      for (int d = 0; d < dwn; d++) exp_q.push_back(mk(pts[k], 0, 1, 1, 0, 0, 1, k));
      exp_q.push_back(mk(pts[k], 0, 0, 1, 0, 0, 1, k));
    end
    exp_q.push_back(mk(pts[pts.size()-1], 0, 0, 1, 1, 0, 0, 0));
    exp_q.push_back(mk(pts[pts.size()-1], 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_cycle(input exp_t e, input string tag, input int cyc);
    logic [10:0] obs;
    logic [10:0] want;
    obs  = {cal_para, cal_load, cal_start, busy, done, aborted};
    want = {e.para, e.load, e.start, e.busy, e.done, e.abrt};
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc%0d {para,load,start,busy,done,aborted} observed=%h expected=%h",
             tag, cyc, obs, want);
    end
    if (e.chk_idx) begin
      n_total++;
      assert (point_idx === e.idx) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s cyc%0d point_idx observed=%0d expected=%0d", tag, cyc, point_idx, e.idx);
      end
    end
  endtask

  // Launch a sweep and compare every cycle against the model.
  // abort_at / busy_start_at / rst_at: timeline index after which the event is driven (-1 = none)
  task automatic run_sweep(input string tag, input int first, input int last, input int step,
                           input int stl, input int dw, input int abort_at,
                           input int busy_start_at, input int rst_at, input bit abort_with_start);
    exp_t held;
    build_model(first, last, step, stl, dw);
    if (abort_at >= 0) begin
      held   = exp_q[abort_at];
      exp_q  = exp_q[0:abort_at];
      exp_q.push_back(mk(held.para, 0, 0, 1, 0, 1, 0, 0));
      exp_q.push_back(mk(held.para, 0, 0, 0, 0, 0, 0, 0));
    end
    if (rst_at >= 0) exp_q = exp_q[0:rst_at];
    para_first = 6'(first);
    para_last  = 6'(last);
    para_step  = 6'(step);
    settle     = 8'(stl);
    dwell      = 16'(dw);
    seq_start  = 1'b1;
    seq_abort  = abort_with_start;
    @(negedge clk_sys);
    seq_start  = 1'b0;
    seq_abort  = 1'b0;
    // Configuration is shadowed; later input changes must not matter
    para_first = 6'($urandom);
    para_last  = 6'($urandom);
    para_step  = 6'($urandom);
    settle     = 8'($urandom);
    dwell      = 16'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_cycle(exp_q[i], tag, i);
      seq_abort = (i == abort_at);
      seq_start = (i == busy_start_at);
      if (i == rst_at) rst_n = 1'b0;
      @(negedge clk_sys);
    end
    seq_abort = 1'b0;
    seq_start = 1'b0;
    if (rst_at >= 0) begin
      check_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0), {tag, "_reset"}, 0);
      rst_n = 1'b1;
      @(negedge clk_sys);
      check_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0), {tag, "_post_reset"}, 1);
    end
  endtask

  initial begin
    int f, l, s, st, dw;
    rst_n      = 1'b0;
    seq_start  = 1'b0;
    seq_abort  = 1'b0;
    para_first = 6'd0;
    para_last  = 6'd0;
    para_step  = 6'd0;
    settle     = 8'd0;
    dwell      = 16'd0;
    repeat (2) @(negedge clk_sys);
    check_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0), "reset", 0);
    rst_n = 1'b1;
    // abort alone in IDLE is ignored
    seq_abort = 1'b1;
    @(negedge clk_sys);
    seq_abort = 1'b0;
    check_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0), "idle_abort", 0);

    // Normal sweep with an ignored seq_start while busy
    run_sweep("normal", 4, 10, 3, 2, 5, -1, 2, -1, 1'b0);
    // Overflow past 63 ends after one point
    run_sweep("overflow", 60, 63, 5, 1, 2, -1, -1, -1, 1'b0);
    // step=0 gives one point
    run_sweep("step0", 20, 30, 0, 1, 1, -1, -1, -1, 1'b0);
    // first>last gives one point
    run_sweep("first_gt_last", 40, 10, 1, 0, 2, -1, -1, -1, 1'b0);
    // Zero settle/dwell; start with abort in IDLE starts the sweep
    run_sweep("zero_counts", 1, 1, 1, 0, 0, -1, -1, -1, 1'b1);
    // Abort during the second RUN (point length 1+1+4+1=7, RUN starts at 9)
    run_sweep("abort", 4, 20, 4, 1, 4, 10, 1, -1, 1'b0);
    // Restart after abort from a new first value
    run_sweep("restart", 33, 40, 2, 0, 1, -1, -1, -1, 1'b0);
    // Reset mid-RUN (RUN spans indices 3..8)
    run_sweep("rst_mid_run", 5, 30, 5, 2, 6, -1, -1, 4, 1'b0);
    // Back-to-back sweep after reset
    run_sweep("after_reset", 62, 63, 1, 1, 1, -1, -1, -1, 1'b0);

    // Randomized sweeps
    for (int r = 0; r < 8; r++) begin
      f  = $urandom_range(0, 63);
      l  = $urandom_range(0, 63);
      s  = $urandom_range(0, 9);
      st = $urandom_range(0, 3);
      dw = $urandom_range(0, 4);
      run_sweep("random", f, l, s, st, dw, -1, (r % 2 == 0) ? 1 : -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
